// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the CSR scan chain controller.
// Holds the controller state encoding and the CRC-8 parameters
// (polynomial 0x07, init 0x00, no reflection, no final XOR).
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    UNLOAD,
    CRC
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/scan_crc8.sv
// Purpose : CRC-8 accumulator over WIDTH-bit words, each word consumed MSB first.
// Latency : the updated CRC is visible the cycle after en; clr wins over en.
// Backpr. : none; the caller pulses en only on accepted words.
// Ports   : clk, rst (sync, active-low), clr, en, dat[WIDTH-1:0] -> crc[7:0].
module scan_crc8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] dat,
  output logic [7:0]       crc
);
  import scan_ctrl_pkg::*;

  logic [7:0] crc_q, crc_d;
  logic [7:0] step;

  always_comb begin
    // Serial LFSR unrolled across the word, MSB first.
    step = crc_q;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (step[7] ^ dat[i]) begin
        step = {step[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        step = {step[6:0], 1'b0};
      end
    end
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC8_INIT;
    end else if (en) begin
      crc_d = step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= CRC8_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/scan_chain_controller.sv
// Purpose : loads a CHAIN_LEN-bit image from the host, shifts it through the CSR scan
//           chain while capturing the old contents, then streams the capture back.
// Latency : NWORDS load + CHAIN_LEN shift + NWORDS unload cycles minimum; done pulses
//           in the first IDLE cycle afterwards.
// Backpr. : wr_ready low outside IDLE/LOAD; unload holds rd_data until rd_ready.
// Ports   : clk, rst (sync, active-low); wr_data/wr_valid/wr_ready host load stream;
//           rd_data/rd_valid/rd_ready capture stream; scan_enable/scan_chain_in/
//           scan_chain_out chain port; processor_enable, busy, done status.
// Option  : define SCAN_CTRL_CRC_EN to append a CRC-8 word after the captured image.
// Note    : CHAIN_LEN must be a multiple of WIDTH and at least 2.
module scan_chain_controller #(
  parameter int WIDTH     = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             scan_enable,
  output logic             scan_chain_in,
  input  logic             scan_chain_out,
  output logic             processor_enable,
  output logic             busy,
  output logic             done
);
  import scan_ctrl_pkg::*;

  localparam int NWORDS = CHAIN_LEN / WIDTH;
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int BCW    = $clog2(CHAIN_LEN);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [WCW-1:0]       word_cnt_q, word_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CHAIN_LEN-1:0] buf_q, buf_d;
  logic                 done_q, done_d;

`ifdef SCAN_CTRL_CRC_EN
  logic       crc_clr, crc_en;
  logic [7:0] crc_val;

  scan_crc8 #(.WIDTH(WIDTH)) u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .dat (rd_data),
    .crc (crc_val)
  );
`endif

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    buf_d      = buf_q;
    done_d     = 1'b0;
`ifdef SCAN_CTRL_CRC_EN
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          buf_d[WIDTH-1:0] = wr_data;
`ifdef SCAN_CTRL_CRC_EN
          crc_clr = 1'b1;
`endif
          if (NWORDS == 1) begin
            state_d    = SHIFT;
            word_cnt_d = '0;
          end else begin
            state_d    = LOAD;
            word_cnt_d = WCW'(1);
          end
        end
      end
      LOAD: begin
        if (wr_valid) begin
          buf_d[int'(word_cnt_q)*WIDTH +: WIDTH] = wr_data;
          if (word_cnt_q == LAST_WORD) begin
            state_d    = SHIFT;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      SHIFT: begin
        // LSB leaves on scan_chain_in this cycle; chain output enters at the MSB,
        // so after CHAIN_LEN shifts captured bit i lands in buffer bit i.
        buf_d = {scan_chain_out, buf_q[CHAIN_LEN-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = UNLOAD;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      UNLOAD: begin
        if (rd_ready) begin
`ifdef SCAN_CTRL_CRC_EN
          crc_en = 1'b1;
`endif
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
`ifdef SCAN_CTRL_CRC_EN
            state_d = CRC;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
`ifdef SCAN_CTRL_CRC_EN
      CRC: begin
        if (rd_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
    end
  end

  // Image buffer contents are meaningless after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    rd_data = '0;
    if (state_q == UNLOAD) begin
      rd_data = buf_q[int'(word_cnt_q)*WIDTH +: WIDTH];
    end
`ifdef SCAN_CTRL_CRC_EN
    if (state_q == CRC) begin
      rd_data = WIDTH'(crc_val);
    end
`endif
  end

`ifdef SCAN_CTRL_CRC_EN
  assign rd_valid = (state_q == UNLOAD) || (state_q == CRC);
`else
  assign rd_valid = (state_q == UNLOAD);
`endif
  assign wr_ready         = (state_q == IDLE) || (state_q == LOAD);
  assign scan_enable      = (state_q == SHIFT);
  assign scan_chain_in    = (state_q == SHIFT) && buf_q[0];
  assign processor_enable = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
module tb_scan_chain_controller;
`ifdef SCAN_CTRL_CRC_EN
  localparam int CL = 72;
  localparam int XW = 1;
`else
  localparam int CL = 64;
  localparam int XW = 0;
`endif
  localparam int W  = 8;
  localparam int NW = CL / W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready = 1'b1;
  logic         scan_enable, scan_chain_in, scan_chain_out;
  logic         processor_enable, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scan_chain_controller #(.WIDTH(W), .CHAIN_LEN(CL)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_data          (wr_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .scan_enable      (scan_enable),
    .scan_chain_in    (scan_chain_in),
    .scan_chain_out   (scan_chain_out),
    .processor_enable (processor_enable),
    .busy             (busy),
    .done             (done)
  );

  // Chain under test: a plain shift register, scan_in at the MSB, scan_out from bit 0.
  logic [CL-1:0] chain, chain_init;
  logic          chain_load = 1'b1;
  always @(posedge clk) begin
    if (chain_load) chain <= chain_init;
    else if (scan_enable) chain <= {scan_chain_in, chain[CL-1:1]};
  end
  assign scan_chain_out = chain[0];

  // Reference: one full pass returns the old chain contents and leaves the new image.
  logic [CL-1:0] model_chain;
  logic [W-1:0]  exp_q[$];
  bit            stall = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] crc_ref(input logic [W-1:0] q[$]);
    logic [7:0] c = 8'h00;
    foreach (q[n]) begin
      c = c ^ 8'(q[n]);
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    #1;
    rd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor / compare process
  bit           in_txn = 0, txn_end = 0, expect_done = 0, hold_pend = 0;
  logic [W-1:0] held;
  int           wr_cnt, rd_cnt, se_cnt, first_se, last_se, last_wr, first_rv;
  int           done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      in_txn = 0; hold_pend = 0; expect_done = 0;
    end else begin
      if (expect_done) begin
        chk("done_pulse", done, 1);
        chk("pe_after_done", processor_enable, 1);
        chk("busy_after_done", busy, 0);
        expect_done = 0;
      end else begin
        chk("done_quiet", done, 0);
      end
      if (hold_pend) chk("rd_hold", rd_data, held);
      hold_pend = rd_valid && !rd_ready;
      held = rd_data;
      if (in_txn) chk("pe_low", processor_enable, 0);
      else begin
        chk("pe_idle", processor_enable, 1);
        chk("se_idle", scan_enable, 0);
      end
      if (scan_enable) begin
        if (se_cnt == 0) first_se = cyc;
        last_se = cyc;
        se_cnt++;
      end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (done) done_cnt++;
      if (wr_valid && wr_ready) begin
        if (!in_txn) begin
          in_txn = 1; wr_cnt = 0; rd_cnt = 0; se_cnt = 0; first_rv = -1; txn_end = 0;
        end
        wr_cnt++;
        if (wr_cnt == NW) last_wr = cyc;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra: got word %0h expected no word", rd_data);
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
        rd_cnt++;
        if (rd_cnt == NW + XW) begin
          in_txn = 0; txn_end = 1; expect_done = 1;
        end
      end
    end
  end

  task automatic load_img(input logic [CL-1:0] img, input bit gaps);
    int tmo;
    for (int k = 0; k < NW; k++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      wr_valid = 1'b1;
      wr_data  = img[k*W +: W];
      tmo = 0;
      while (!wr_ready && tmo < 1000) begin tick(); tmo++; end
      chk("wr_accept", wr_ready, 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_data  = W'($urandom);
  endtask

  task automatic run_txn(input logic [CL-1:0] img, input bit gaps, input bit stalls);
    logic [W-1:0] words[$];
    int tmo, d0;
    for (int k = 0; k < NW; k++) begin
      words.push_back(model_chain[k*W +: W]);
      exp_q.push_back(model_chain[k*W +: W]);
    end
    if (XW != 0) exp_q.push_back(W'(crc_ref(words)));
    model_chain = img;
    stall = stalls;
    d0 = done_cnt;
    load_img(img, gaps);
    tmo = 0;
    while (!txn_end && tmo < 5000) begin tick(); tmo++; end
    chk("txn_complete", txn_end, 1);
    repeat (3) tick();
    chk("se_count", se_cnt, CL);
    chk("se_contig", last_se - first_se + 1, CL);
    chk("se_start", first_se, last_wr + 1);
    chk("rv_start", first_rv, last_se + 1);
    chk("done_once", done_cnt - d0, 1);
    chk("exp_drained", exp_q.size(), 0);
    exp_q.delete();
    stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CL-1:0] img_a, img_ff, img_r;
    chain_init = '0;
`ifdef SCAN_CTRL_CRC_EN
    for (int k = 0; k < NW; k++) chain_init[k*W +: W] = 8'h31 + 8'(k);
`endif
    model_chain = chain_init;
    for (int k = 0; k < NW; k++) img_a[k*W +: W] = W'(k + 1);
    img_ff = '1;

    rst = 1'b0;
    repeat (2) tick();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_pe", processor_enable, 1);
    chk("rst_se", scan_enable, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_scan_in", scan_chain_in, 0);
    chain_load = 1'b0;
    rst = 1'b1;
    tick();

`ifdef SCAN_CTRL_CRC_EN
    begin
      logic [W-1:0] ascii[$];
      for (int k = 0; k < 9; k++) ascii.push_back(8'h31 + 8'(k));
      chk("crc_pin", crc_ref(ascii), 8'hF4);
    end
`endif

    run_txn(img_a, 0, 0);
`ifdef SCAN_CTRL_CRC_EN
    chk("model_pin_a", model_chain, 72'h090807060504030201);
`else
    chk("model_pin_a", model_chain, 64'h0807060504030201);
`endif
    run_txn(img_ff, 0, 0);
    chk("model_pin_ff", model_chain, {CL{1'b1}});
    run_txn(img_a, 1, 1);

    // Reset in the middle of the shift: 21 bits reach the chain (cycles 0..20).
    for (int k = 0; k < NW; k++) img_r[k*W +: W] = W'($urandom);
    load_img(img_r, 0);
    chk("shift_entered", scan_enable, 1);
    repeat (20) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_se", scan_enable, 0);
    chk("mid_rst_pe", processor_enable, 1);
    chk("mid_rst_wr_ready", wr_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    rst = 1'b1;
    model_chain = CL'({img_r, model_chain} >> 21);
    tick();

    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < NW; k++) img_r[k*W +: W] = W'($urandom);
      run_txn(img_r, t != 0, 1);
    end
    chk("done_total", done_cnt, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
